bin2bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter for the calculator datapath. It replaces single-cycle combinational conversion on wide operands with an iterative shift-add-3 (double-dabble) engine that processes one input bit per clock. A start/busy/done handshake connects it to the result register and to the display digit drivers. An optional signed mode emits a sign flag plus the BCD magnitude, and an overflow flag reports when DIGITS is too small for the value.

---
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one operand bit per clock.
// Optional two's-complement input yields a sign flag plus BCD magnitude.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   SHIFT | one add-3/shift iteration per clock, WIDTH iterations
//   DONE  | result registers valid, done pulse, back to IDLE
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    binary,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                sign,
    output logic                overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    opnd, opnd_nxt;
    logic [4*DIGITS-1:0] scratch, scratch_adj, scratch_nxt;
    logic                shift_out;
    logic                ovf_lat;
    logic                sign_lat;
    logic [CW-1:0]       cnt;
    logic                last_bit;
    logic                neg_in;

    assign neg_in   = (SIGNED != 0) && binary[WIDTH-1];
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Per-digit add-3 with no carry between digits; a digit <= 9 stays within 4 bits.
    always_comb begin
        scratch_adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
    end

    assign {shift_out, scratch_nxt, opnd_nxt} = {scratch_adj, opnd, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results load on the final shift edge so they are valid during DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd     <= '0;
            scratch  <= '0;
            ovf_lat  <= 1'b0;
            sign_lat <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opnd     <= neg_in ? -binary : binary;
                        sign_lat <= neg_in;
                        scratch  <= '0;
                        ovf_lat  <= 1'b0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    opnd    <= opnd_nxt;
                    scratch <= scratch_nxt;
                    ovf_lat <= ovf_lat | shift_out;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        bcd      <= scratch_nxt;
                        overflow <= ovf_lat | shift_out;
                        sign     <= sign_lat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
